// File: rtl/fetch_unit_q.sv
// Instruction fetch stage: prioritised next-PC selection, in-order imem requests,
// and a PC-tagged fetch queue feeding decode. Any redirect flushes queued and in-flight work.
module fetch_unit_q #(
    parameter int               XLEN         = 32,
    parameter int               ILEN         = 32,
    parameter int               QDEPTH       = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        exc_valid,
    input  logic [XLEN-1:0]             exc_target,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_target,
    input  logic                        pred_valid,
    input  logic [XLEN-1:0]             pred_target,
    input  logic                        stall,
    output logic                        imem_req_valid,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_req_ready,
    input  logic                        imem_rsp_valid,
    input  logic [ILEN-1:0]             imem_rsp_data,
    output logic                        dec_valid,
    output logic [XLEN-1:0]             dec_pc,
    output logic [ILEN-1:0]             dec_instr,
    input  logic                        dec_ready,
    output logic                        misaligned_exc,
    output logic [$clog2(QDEPTH):0]     outstanding
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    // Stale responses can pile up across back-to-back flushes, so the discard
    // counter is wider than the queue occupancy counters.
    localparam int DW = AW + 4;

    logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [AW-1:0]     head_reg, head_next;
    logic [AW-1:0]     fill_reg, fill_next;
    logic [AW-1:0]     tail_reg, tail_next;
    logic [CW-1:0]     alloc_cnt_reg, alloc_cnt_next;
    logic [CW-1:0]     unfilled_cnt_reg, unfilled_cnt_next;
    logic [DW-1:0]     discard_reg, discard_next;
    logic [DW-1:0]     stale_total;
    logic              misaligned_exc_reg, misaligned_exc_next;
    logic [QDEPTH-1:0] filled_reg, filled_next;

    logic [XLEN-1:0]   pc_mem    [QDEPTH];
    logic [ILEN-1:0]   instr_mem [QDEPTH];

    logic flush;
    logic misaligned_redirect;
    logic queue_full;
    logic accept;
    logic rsp_live;
    logic do_fill;
    logic do_discard;
    logic do_pop;

    assign flush               = exc_valid || redirect_valid;
    assign misaligned_redirect = redirect_valid && !exc_valid && (redirect_target[1:0] != 2'b00);
    assign queue_full          = (alloc_cnt_reg == CW'(QDEPTH));

    assign imem_req_valid = !reset && !stall && !flush && !queue_full;
    assign imem_req_addr  = fetch_pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response in the flush cycle is dropped outright; otherwise it either
    // retires a stale request or fills the oldest unfilled entry.
    assign rsp_live   = imem_rsp_valid && !flush;
    assign do_discard = rsp_live && (discard_reg != '0);
    assign do_fill    = rsp_live && (discard_reg == '0) && (unfilled_cnt_reg != '0);

    assign dec_valid = filled_reg[head_reg];
    assign dec_pc    = pc_mem[head_reg];
    assign dec_instr = instr_mem[head_reg];
    assign do_pop    = dec_valid && dec_ready && !flush;

    assign misaligned_exc = misaligned_exc_reg;
    assign outstanding    = unfilled_cnt_reg;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (exc_valid) begin
            fetch_pc_next = exc_target;
        end else if (misaligned_redirect) begin
            fetch_pc_next = exc_target;
        end else if (redirect_valid) begin
            fetch_pc_next = redirect_target;
        end else if (accept && pred_valid) begin
            fetch_pc_next = pred_target;
        end else if (accept) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
        end
    end

    assign misaligned_exc_next = misaligned_redirect;

    always_comb begin
        stale_total  = discard_reg + DW'(unfilled_cnt_reg);
        discard_next = discard_reg;
        if (flush) begin
            discard_next = stale_total - DW'(imem_rsp_valid && (stale_total != '0));
        end else if (do_discard) begin
            discard_next = discard_reg - DW'(1);
        end
    end

    always_comb begin
        head_next         = head_reg + AW'(do_pop);
        fill_next         = fill_reg + AW'(do_fill);
        tail_next         = tail_reg + AW'(accept);
        alloc_cnt_next    = alloc_cnt_reg + CW'(accept) - CW'(do_pop);
        unfilled_cnt_next = unfilled_cnt_reg + CW'(accept) - CW'(do_fill);
        if (flush) begin
            head_next         = '0;
            fill_next         = '0;
            tail_next         = '0;
            alloc_cnt_next    = '0;
            unfilled_cnt_next = '0;
        end
    end

    // Fill, pop and allocate always target distinct entries, so their order here is immaterial.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
            assign filled_next[gi] =
                flush                                   ? 1'b0 :
                (do_fill && (fill_reg == AW'(gi)))      ? 1'b1 :
                (do_pop  && (head_reg == AW'(gi)))      ? 1'b0 :
                (accept  && (tail_reg == AW'(gi)))      ? 1'b0 :
                                                          filled_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_reg       <= RESET_VECTOR;
            head_reg           <= '0;
            fill_reg           <= '0;
            tail_reg           <= '0;
            alloc_cnt_reg      <= '0;
            unfilled_cnt_reg   <= '0;
            discard_reg        <= '0;
            misaligned_exc_reg <= 1'b0;
            filled_reg         <= '0;
        end else begin
            fetch_pc_reg       <= fetch_pc_next;
            head_reg           <= head_next;
            fill_reg           <= fill_next;
            tail_reg           <= tail_next;
            alloc_cnt_reg      <= alloc_cnt_next;
            unfilled_cnt_reg   <= unfilled_cnt_next;
            discard_reg        <= discard_next;
            misaligned_exc_reg <= misaligned_exc_next;
            filled_reg         <= filled_next;
        end
    end

    // Payload storage needs no reset: the filled bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_mem[tail_reg] <= fetch_pc_reg;
        end
        if (do_fill) begin
            instr_mem[fill_reg] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit_q.sv
// Directed bench for fetch_unit_q with an in-order, fixed-latency instruction memory model.
// Instruction words are the bitwise inverse of their address so dec_instr can be checked.
module tb_fetch_unit_q;

    localparam int          XLEN   = 32;
    localparam int          ILEN   = 32;
    localparam int          QDEPTH = 4;
    localparam logic [31:0] RV     = 32'h100;

    logic              clk = 1'b0;
    logic              reset;
    logic              exc_valid;
    logic [XLEN-1:0]   exc_target;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_target;
    logic              pred_valid;
    logic [XLEN-1:0]   pred_target;
    logic              stall;
    logic              imem_req_valid;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [ILEN-1:0]   imem_rsp_data;
    logic              dec_valid;
    logic [XLEN-1:0]   dec_pc;
    logic [ILEN-1:0]   dec_instr;
    logic              dec_ready;
    logic              misaligned_exc;
    logic [2:0]        outstanding;

    always #5 clk = ~clk;

    fetch_unit_q #(
        .XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH), .RESET_VECTOR(RV)
    ) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pred_valid(pred_valid), .pred_target(pred_target),
        .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_ready(dec_ready),
        .misaligned_exc(misaligned_exc), .outstanding(outstanding)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int mem_lat    = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc;

    // One clock cycle: memory answers/accepts on settled values, then step to the next negedge.
    task automatic tick;
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        if (imem_req_valid && imem_req_ready) begin
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + mem_lat);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        tick();
        redirect_valid  = 1'b0;
    endtask

    task automatic drain(input int n);
        stall     = 1'b1;
        dec_ready = 1'b1;
        repeat (n) tick();
        #1;
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL drain_outstanding: got %0d expected 0", outstanding); end
        vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL drain_dec_valid: got %b expected 0", dec_valid); end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
        vectors++; if (imem_req_addr !== RV) begin miscompares++; $display("FAIL reset_fetch_pc: got %h expected %h", imem_req_addr, RV); end
        vectors++; if (misaligned_exc !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned: got %b expected 0", misaligned_exc); end
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    endtask

    task automatic test_sequential;
        reset     = 1'b0;
        dec_ready = 1'b1;
        mem_lat   = 1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_pc = RV + 32'(4 * k);
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin miscompares++; $display("FAIL seq_req k=%0d: got valid=%b addr=%h expected valid=1 addr=%h", k, imem_req_valid, imem_req_addr, exp_pc); end
            if (k < 2) begin
                vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL seq_dec_early k=%0d: got %b expected 0", k, dec_valid); end
            end else begin
                exp_pc = RV + 32'(4 * (k - 2));
                vectors++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== ~exp_pc) begin miscompares++; $display("FAIL seq_dec k=%0d: got valid=%b pc=%h instr=%h expected pc=%h instr=%h", k, dec_valid, dec_pc, dec_instr, exp_pc, ~exp_pc); end
            end
            tick();
        end
        drain(4);
    endtask

    task automatic test_full;
        stall           = 1'b0;
        dec_ready       = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_flush_noreq: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_pc = 32'(4 * k);
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin miscompares++; $display("FAIL full_req k=%0d: got valid=%b addr=%h expected %h", k, imem_req_valid, imem_req_addr, exp_pc); end
            tick();
        end
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_blocked: got %b expected 0", imem_req_valid); end
        tick(); tick();
        #1;
        vectors++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h0) begin miscompares++; $display("FAIL full_held: got req=%b dec_valid=%b dec_pc=%h expected 0 1 0", imem_req_valid, dec_valid, dec_pc); end
        vectors++; if (outstanding !== 3'd0) begin miscompares++; $display("FAIL full_outstanding: got %0d expected 0", outstanding); end
        dec_ready = 1'b1;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass: got %b expected 0", imem_req_valid); end
        tick();
        for (int k = 1; k <= 4; k++) begin
            #1;
            exp_pc = 32'(4 * k);
            vectors++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin miscompares++; $display("FAIL full_pop k=%0d: got valid=%b pc=%h expected %h", k, dec_valid, dec_pc, exp_pc); end
            if (k <= 2) begin
                exp_pc = 32'h10 + 32'(4 * (k - 1));
                vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin miscompares++; $display("FAIL full_resume k=%0d: got valid=%b addr=%h expected %h", k, imem_req_valid, imem_req_addr, exp_pc); end
            end
            tick();
        end
        drain(4);
    endtask

    task automatic test_prediction;
        stall     = 1'b0;
        dec_ready = 1'b1;
        redirect_to(32'h0);
        #1; vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL pred_c0: got %h expected 0", imem_req_addr); end
        tick();
        #1; vectors++; if (imem_req_addr !== 32'h4) begin miscompares++; $display("FAIL pred_c1: got %h expected 4", imem_req_addr); end
        tick();
        pred_valid  = 1'b1;
        pred_target = 32'h200;
        #1; vectors++; if (imem_req_addr !== 32'h8) begin miscompares++; $display("FAIL pred_c2: got %h expected 8", imem_req_addr); end
        tick();
        pred_valid = 1'b0;
        #1; vectors++; if (imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL pred_taken: got %h expected 200", imem_req_addr); end
        tick();
        #1; vectors++; if (imem_req_addr !== 32'h204) begin miscompares++; $display("FAIL pred_seq: got %h expected 204", imem_req_addr); end
        tick();
        #1; vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200) begin miscompares++; $display("FAIL pred_dec: got valid=%b pc=%h expected 200", dec_valid, dec_pc); end
        imem_req_ready = 1'b0;
        pred_valid     = 1'b1;
        pred_target    = 32'h300;
        #1; vectors++; if (imem_req_addr !== 32'h208) begin miscompares++; $display("FAIL pred_c5: got %h expected 208", imem_req_addr); end
        tick();
        #1; vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h208) begin miscompares++; $display("FAIL pred_no_accept: got valid=%b addr=%h expected 208", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        pred_valid     = 1'b0;
        tick();
        #1; vectors++; if (imem_req_addr !== 32'h20C) begin miscompares++; $display("FAIL pred_resume: got %h expected 20c", imem_req_addr); end
        drain(4);
    endtask

    task automatic test_redirect;
        stall     = 1'b0;
        dec_ready = 1'b1;
        mem_lat   = 3;
        redirect_to(32'h0);
        tick();
        tick();
        #1; vectors++; if (outstanding !== 3'd2) begin miscompares++; $display("FAIL redir_inflight: got %0d expected 2", outstanding); end
        redirect_valid  = 1'b1;
        redirect_target = 32'h400;
        #1; vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_noreq: got %b expected 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1; vectors++; if (imem_req_addr !== 32'h400) begin miscompares++; $display("FAIL redir_pc: got %h expected 400", imem_req_addr); end
        for (int k = 3; k <= 6; k++) begin
            #1; vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL redir_stale c%0d: got dec_valid=%b pc=%h expected 0", k, dec_valid, dec_pc); end
            tick();
        end
        #1; vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h400 || dec_instr !== ~32'h400) begin miscompares++; $display("FAIL redir_first: got valid=%b pc=%h instr=%h expected 400", dec_valid, dec_pc, dec_instr); end
        tick();
        #1; vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h404) begin miscompares++; $display("FAIL redir_second: got valid=%b pc=%h expected 404", dec_valid, dec_pc); end
        drain(8);
    endtask

    task automatic test_priority;
        stall           = 1'b1;
        exc_valid       = 1'b1;
        exc_target      = 32'h80;
        redirect_valid  = 1'b1;
        redirect_target = 32'h402;
        tick();
        exc_valid      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        vectors++; if (imem_req_addr !== 32'h80 || misaligned_exc !== 1'b0) begin miscompares++; $display("FAIL prio_exc: got pc=%h misaligned=%b expected 80 0", imem_req_addr, misaligned_exc); end
        redirect_to(32'h500);
        #1; vectors++; if (imem_req_addr !== 32'h500) begin miscompares++; $display("FAIL prio_redir: got %h expected 500", imem_req_addr); end
        redirect_valid  = 1'b1;
        redirect_target = 32'h402;
        #1; vectors++; if (misaligned_exc !== 1'b0) begin miscompares++; $display("FAIL mis_early: got %b expected 0", misaligned_exc); end
        tick();
        redirect_valid = 1'b0;
        #1; vectors++; if (imem_req_addr !== 32'h80 || misaligned_exc !== 1'b1) begin miscompares++; $display("FAIL mis_pulse: got pc=%h misaligned=%b expected 80 1", imem_req_addr, misaligned_exc); end
        tick();
        #1; vectors++; if (misaligned_exc !== 1'b0 || imem_req_addr !== 32'h80) begin miscompares++; $display("FAIL mis_end: got pc=%h misaligned=%b expected 80 0", imem_req_addr, misaligned_exc); end
        stall = 1'b0;
    endtask

    task automatic test_async_reset;
        stall     = 1'b0;
        dec_ready = 1'b0;
        mem_lat   = 3;
        redirect_to(32'h0);
        tick(); tick(); tick();
        stall = 1'b1;
        #1; vectors++; if (outstanding !== 3'd3) begin miscompares++; $display("FAIL ar_three: got %0d expected 3", outstanding); end
        tick();
        #1; vectors++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || outstanding !== 3'd2) begin miscompares++; $display("FAIL ar_before: got valid=%b pc=%h outstanding=%0d expected 1 0 2", dec_valid, dec_pc, outstanding); end
        reset = 1'b1;
        #1;
        vectors++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL ar_immediate: got dec_valid=%b req_valid=%b expected 0 0", dec_valid, imem_req_valid); end
        vectors++; if (imem_req_addr !== RV || outstanding !== 3'd0) begin miscompares++; $display("FAIL ar_state: got pc=%h outstanding=%0d expected %h 0", imem_req_addr, outstanding, RV); end
        tick();
        reset = 1'b0;
        tick();
        tick();
        #1; vectors++; if (dec_valid !== 1'b0 || outstanding !== 3'd0) begin miscompares++; $display("FAIL ar_late_rsp: got dec_valid=%b outstanding=%0d expected 0 0", dec_valid, outstanding); end
        stall     = 1'b0;
        dec_ready = 1'b1;
        mem_lat   = 1;
        #1; vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RV) begin miscompares++; $display("FAIL ar_restart: got valid=%b addr=%h expected %h", imem_req_valid, imem_req_addr, RV); end
        tick(); tick();
        #1; vectors++; if (dec_valid !== 1'b1 || dec_pc !== RV || dec_instr !== ~RV) begin miscompares++; $display("FAIL ar_first_dec: got valid=%b pc=%h instr=%h expected %h", dec_valid, dec_pc, dec_instr, RV); end
        drain(4);
    endtask

    initial begin
        reset           = 1'b1;
        exc_valid       = 1'b0;
        exc_target      = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        pred_valid      = 1'b0;
        pred_target     = '0;
        stall           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        dec_ready       = 1'b0;

        test_reset();
        test_sequential();
        test_full();
        test_prediction();
        test_redirect();
        test_priority();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit_q.md
Name: fetch_unit_q

Overview:
Parametrised next-generation instruction fetch stage.
- Generates the fetch PC with a prioritised redirect scheme: trap > misaligned redirect > pipeline redirect > branch prediction > sequential.
- Issues in-order requests to instruction memory through a valid/ready handshake.
- Buffers fetched instructions, tagged with their PCs, in a QDEPTH-entry queue that feeds decode through a valid/ready handshake.
- Flushes in-flight and buffered work on any redirect.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
QDEPTH, 4, fetch queue entries (power of 2, >=2)
RESET_VECTOR, 0, PC loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
exc_valid  in  1  trap request (highest priority)
exc_target  in  XLEN  trap vector (mtvec)
redirect_valid  in  1  resolved jump/branch redirect from execute
redirect_target  in  XLEN  redirect address
pred_valid  in  1  predictor says the PC being requested this cycle is a taken branch
pred_target  in  XLEN  predicted target
stall  in  1  suppress new memory requests (queue and decode unaffected)
imem_req_valid  out  1  fetch request
imem_req_addr  out  XLEN  equals fetch_pc
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  in-order response
imem_rsp_data  in  ILEN  instruction word
dec_valid  out  1  head entry holds an instruction
dec_pc  out  XLEN  PC of head entry
dec_instr  out  ILEN  instruction of head entry
dec_ready  in  1  decode consumes head
misaligned_exc  out  1  one-cycle pulse: redirect target had addr[1:0]!=0
outstanding  out  log2(QDEPTH)+1  allocated-but-unfilled entries (debug)

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_VECTOR, queue empty, all pointers=0, discard=0, misaligned_exc=0, dec_valid=0, imem_req_valid=0.
- Request handshake:
  - imem_req_valid = !stall && !flush_this_cycle && alloc_count<QDEPTH, where alloc_count = filled + unfilled entries.
  - Accept = imem_req_valid && imem_req_ready.
  - On accept, allocate the tail entry (pc=fetch_pc, filled=0) and advance the tail.
- Next-PC priority, registered at the clock edge:
  1. exc_valid: fetch_pc=exc_target; flush.
  2. redirect_valid && redirect_target[1:0]!=0: fetch_pc=exc_target, misaligned_exc=1 next cycle; flush.
  3. redirect_valid: fetch_pc=redirect_target; flush.
  4. accept && pred_valid: fetch_pc=pred_target.
  5. accept: fetch_pc=fetch_pc+4, wrapping modulo 2^XLEN.
  6. Otherwise fetch_pc holds. pred_valid without accept is ignored.
- Response handling: imem_rsp_valid fills the oldest unfilled entry with imem_rsp_data. Memory latency is >=1 cycle and responses are in order.
- Decode: dec_valid=head.filled; dec_pc/dec_instr come from the head entry. On dec_valid && dec_ready the head pops. Pop, fill and allocate may all occur in one cycle.
- Flush, on rule 1/2/3 in the cycle it is asserted:
  - All entries are invalidated.
  - discard = current unfilled count (excluding any entry filled this cycle).
  - No request is issued in the flush cycle. Requests resume the next cycle from the new fetch_pc.
  - While discard>0, each imem_rsp_valid decrements discard and writes nothing.
  - An imem_rsp_valid arriving in the flush cycle itself is dropped and is not counted against discard.
  - dec_valid is 0 the cycle after a flush.
- Full: alloc_count==QDEPTH forces imem_req_valid=0. A pop in the same cycle frees a slot only from the next cycle (no same-cycle bypass).
- Empty: dec_valid=0. A response never bypasses the queue; minimum fetch-to-decode latency is response cycle +1.
- stall does not block responses, fills or pops, and does not block redirects.
- Asserting reset mid-operation immediately restores the reset state; all pending responses are forgotten.

Test Plan:
- Sequential: release reset with RESET_VECTOR=0x100, memory with 1-cycle latency and dec_ready=1 -> imem_req_addr=0x100,0x104,0x108...; dec_pc follows the same sequence starting 2 cycles after the first request.
- Full/backpressure: dec_ready=0, QDEPTH=4 -> exactly 4 requests (0x0..0xC), then imem_req_valid=0. Raise dec_ready -> pops in order and requests resume at 0x10.
- Prediction: pred_valid=1, pred_target=0x200 while the request for 0x8 is accepted -> next imem_req_addr=0x200. pred_valid=1 with imem_req_ready=0 -> address stays unchanged.
- Redirect with 2 in flight: 3-cycle latency, redirect_target=0x400 -> the 2 stale responses are discarded, dec_valid=0, then the first dec_pc=0x400.
- Priority/misaligned: exc_valid and redirect_valid in the same cycle with exc_target=0x80 -> fetch_pc=0x80, misaligned_exc=0. redirect_target=0x402 alone -> fetch_pc=0x80, misaligned_exc pulses for 1 cycle.
- Async reset mid-burst: assert reset between clock edges with the queue at 3 entries -> dec_valid=0, fetch_pc=RESET_VECTOR before the next edge; late responses are ignored after release.
